pipe_regs: RTL and testbench
============================

PIPE_REGS -- requirements
Module: pipe_regs

Interface
REQ-001 Parameter: XLEN, default 32, datapath width.
REQ-002 Parameter: RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-003 Parameter: NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), bubble instruction in Decode.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 Port: clk_i  in  1  clock; all state updates on rising edge.
REQ-006 Port: rst_i  in  1  synchronous active-high reset.
REQ-007 Port: pc_next_f_i  in  XLEN  next PC (PC+4 or branch/jump target).
REQ-008 Port: instr_f_i  in  32  instruction fetched at pc_f_o.
REQ-009 Port: stall_f_i, stall_d_i  in  1 each  hold PC register and Fetch/Decode register.
REQ-010 Port: flush_d_i, flush_e_i  in  1 each  bubble Fetch/Decode and Decode/Execute registers.
REQ-011 Port: ctrl_d_i  in  ctrl_t  decoded controls: reg_write, result_src[1:0], mem_write, branch, jump, alu_ctrl[2:0], alu_src.
REQ-012 Port: rs1_d_i, rs2_d_i, rd_d_i  in  5 each  Decode register indices.
REQ-013 Port: rd1_d_i, rd2_d_i, imm_ext_d_i  in  XLEN each  register-file read data and extended immediate.
REQ-014 Port: pc_f_o  out  XLEN  current fetch PC.
REQ-015 Port: instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o  out  32/XLEN/XLEN/1  Decode-stage contents.
REQ-016 Port: ctrl_e_o, rs1_e_o, rs2_e_o, rd_e_o, rd1_e_o, rd2_e_o, imm_ext_e_o, pc_e_o, pc_plus4_e_o, valid_e_o  out  Execute-stage copies.
REQ-017 Port: bubble_cnt_o  out  32  count of bubbles injected into Execute.

Function
REQ-018 PC register: loads pc_next_f_i each cycle unless stall_f_i=1, which holds it.
REQ-019 Fetch/Decode register: captures instr_f_i, pc_f_o and pc_f_o+4, with valid_d_o=1; holds all contents when stall_d_i=1.
REQ-020 Flush/stall priority at Fetch/Decode: flush_d_i=1 overrides stall_d_i and loads instr_d_o=NOP_INSTR, valid_d_o=0, pc_d_o=0, pc_plus4_d_o=0.
REQ-021 Decode/Execute register: no stall input; captures all Decode-stage inputs every cycle.
REQ-022 Bubble at Decode/Execute: flush_e_i=1 zeroes ctrl_e_o (no reg_write, no mem_write, no branch, no jump), rd_e_o, rs1_e_o, rs2_e_o, rd1_e_o, rd2_e_o, imm_ext_e_o, pc_e_o and pc_plus4_e_o, and sets valid_e_o=0.
REQ-023 Non-flush capture: valid_e_o follows valid_d_o; an invalid Decode stage produces a zero control word in Execute.
REQ-024 Load-use stall (stall_f_i=stall_d_i=flush_e_i=1): PC and Fetch/Decode hold, one bubble enters Execute, and the held instruction advances on the next unstalled cycle.
REQ-025 Taken branch (flush_d_i=flush_e_i=1): both stages bubble in the same edge, and the PC loads pc_next_f_i unless stall_f_i=1.
REQ-026 pc_plus4 arithmetic: XLEN-bit modulo addition; wraps from 32'hFFFF_FFFC to 0.
REQ-027 bubble_cnt_o: increments by 1 on each edge with flush_e_i=1 or valid_d_o=0 captured; saturates at 32'hFFFF_FFFF.
REQ-028 Latency: instr_f_i appears at instr_d_o one cycle later and its controls at ctrl_e_o two cycles later, absent stalls and flushes.

Reset
REQ-029 rst_i=1 at a rising edge sets pc_f_o=RESET_PC, instr_d_o=NOP_INSTR, valid_d_o=0, valid_e_o=0, all other Decode and Execute outputs to 0, and bubble_cnt_o=0.
REQ-030 Reset overrides stall and flush and takes effect mid-stream, discarding in-flight instructions.
REQ-031 Post-reset fetch: the first rising edge after rst_i deasserts loads pc_next_f_i into the PC.

Structure
REQ-032 Shared package riscv_pkg holds ctrl_t (packed struct), the default NOP_INSTR encoding, and the result_src and alu_ctrl enumerations.
REQ-033 Sub-module pipe_stage_reg: one generic enable/clear register parameterised by width and clear value, instantiated for the PC, Fetch/Decode and Decode/Execute registers.

Verification
REQ-034 Scenario: reset, then pc_next_f_i=pc_f_o+4 for 3 cycles -> pc_f_o sequence 0,4,8,12 and instr_d_o lags instr_f_i by 1 cycle.
REQ-035 Scenario: load-use, with stall_f_i=stall_d_i=flush_e_i=1 for 1 cycle -> pc_f_o and instr_d_o held, valid_e_o=0, ctrl_e_o=0, bubble_cnt_o=1.
REQ-036 Scenario: branch flush, with flush_d_i=flush_e_i=1 and pc_next_f_i=32'h100 -> next cycle instr_d_o=32'h0000_0013, valid_d_o=0, valid_e_o=0, pc_f_o=32'h100.
REQ-037 Scenario: stall_d_i=1 with flush_d_i=1 -> flush wins and instr_d_o=NOP_INSTR.
REQ-038 Scenario: pc_f_o=32'hFFFF_FFFC captured into Decode -> pc_plus4_d_o=0.
REQ-039 Scenario: rst_i pulsed during a stall with pc_f_o=32'h40 -> pc_f_o=RESET_PC, both valid bits 0, bubble_cnt_o=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: decoded control word, its field enumerations
// and the canonical bubble instruction.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2,
    RES_IMM = 2'd3
  } result_src_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_ctrl_e;

  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
    logic        branch;
    logic        jump;
    alu_ctrl_e   alu_ctrl;
    logic        alu_src;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // An invalid instruction must never cause architectural side effects.
  function automatic ctrl_t ctrl_gate(input ctrl_t c, input logic valid);
    return valid ? c : ctrl_t'('0);
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register with enable (hold when low) and a clear that
// loads CLR_VAL; clear beats enable, and reset loads the same clear value.
module pipe_stage_reg #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = CLR_VAL;
    end else if (en_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= CLR_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_regs.sv
// PC, Fetch/Decode and Decode/Execute pipeline registers of a 5-stage RISC-V
// core, with stall/flush handling and a saturating Execute bubble counter.
module pipe_regs
  import riscv_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] pc_next_f_i,
  input  logic [31:0]     instr_f_i,
  input  logic            stall_f_i,
  input  logic            stall_d_i,
  input  logic            flush_d_i,
  input  logic            flush_e_i,
  input  ctrl_t           ctrl_d_i,
  input  logic [4:0]      rs1_d_i,
  input  logic [4:0]      rs2_d_i,
  input  logic [4:0]      rd_d_i,
  input  logic [XLEN-1:0] rd1_d_i,
  input  logic [XLEN-1:0] rd2_d_i,
  input  logic [XLEN-1:0] imm_ext_d_i,
  output logic [XLEN-1:0] pc_f_o,
  output logic [31:0]     instr_d_o,
  output logic [XLEN-1:0] pc_d_o,
  output logic [XLEN-1:0] pc_plus4_d_o,
  output logic            valid_d_o,
  output ctrl_t           ctrl_e_o,
  output logic [4:0]      rs1_e_o,
  output logic [4:0]      rs2_e_o,
  output logic [4:0]      rd_e_o,
  output logic [XLEN-1:0] rd1_e_o,
  output logic [XLEN-1:0] rd2_e_o,
  output logic [XLEN-1:0] imm_ext_e_o,
  output logic [XLEN-1:0] pc_e_o,
  output logic [XLEN-1:0] pc_plus4_e_o,
  output logic            valid_e_o,
  output logic [31:0]     bubble_cnt_o
);

  localparam int FD_W = 32 + 2 * XLEN + 1;
  localparam int DE_W = CTRL_W + 15 + 5 * XLEN + 1;
  localparam logic [FD_W-1:0] FD_CLR = {NOP_INSTR, {(2 * XLEN){1'b0}}, 1'b0};

  logic [FD_W-1:0] fd_d;
  logic [FD_W-1:0] fd_q;
  logic [DE_W-1:0] de_d;
  logic [DE_W-1:0] de_q;
  logic [31:0]     bubble_cnt_q;
  logic [31:0]     bubble_cnt_d;

  pipe_stage_reg #(
    .WIDTH  (XLEN),
    .CLR_VAL(RESET_PC)
  ) u_pc_reg (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en_i (~stall_f_i),
    .clr_i(1'b0),
    .d_i  (pc_next_f_i),
    .q_o  (pc_f_o)
  );

  always_comb begin
    fd_d = {instr_f_i, pc_f_o, pc_f_o + XLEN'(4), 1'b1};
  end

  pipe_stage_reg #(
    .WIDTH  (FD_W),
    .CLR_VAL(FD_CLR)
  ) u_fd_reg (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en_i (~stall_d_i),
    .clr_i(flush_d_i),
    .d_i  (fd_d),
    .q_o  (fd_q)
  );

  assign {instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o} = fd_q;

  always_comb begin
    de_d = {ctrl_gate(ctrl_d_i, valid_d_o), rs1_d_i, rs2_d_i, rd_d_i,
            rd1_d_i, rd2_d_i, imm_ext_d_i, pc_d_o, pc_plus4_d_o, valid_d_o};
  end

  // Decode/Execute never holds: a stalled Decode feeds bubbles via flush_e_i.
  pipe_stage_reg #(
    .WIDTH  (DE_W),
    .CLR_VAL('0)
  ) u_de_reg (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en_i (1'b1),
    .clr_i(flush_e_i),
    .d_i  (de_d),
    .q_o  (de_q)
  );

  assign {ctrl_e_o, rs1_e_o, rs2_e_o, rd_e_o, rd1_e_o, rd2_e_o,
          imm_ext_e_o, pc_e_o, pc_plus4_e_o, valid_e_o} = de_q;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if ((flush_e_i || !valid_d_o) && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_regs.sv
// Self-checking bench for pipe_regs: directed pipeline scenarios followed by
// randomized stall/flush/reset traffic against a stage-level reference model.
module tb_pipe_regs;
  import riscv_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_next_f_i;
  logic [31:0] instr_f_i;
  logic        stall_f_i, stall_d_i, flush_d_i, flush_e_i;
  ctrl_t       ctrl_d_i;
  logic [4:0]  rs1_d_i, rs2_d_i, rd_d_i;
  logic [31:0] rd1_d_i, rd2_d_i, imm_ext_d_i;
  logic [31:0] pc_f_o, instr_d_o, pc_d_o, pc_plus4_d_o;
  logic        valid_d_o;
  ctrl_t       ctrl_e_o;
  logic [4:0]  rs1_e_o, rs2_e_o, rd_e_o;
  logic [31:0] rd1_e_o, rd2_e_o, imm_ext_e_o, pc_e_o, pc_plus4_e_o;
  logic        valid_e_o;
  logic [31:0] bubble_cnt_o;

  int checks = 0;
  int errors = 0;

  pipe_regs dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_next_f_i(pc_next_f_i), .instr_f_i(instr_f_i),
    .stall_f_i(stall_f_i), .stall_d_i(stall_d_i), .flush_d_i(flush_d_i), .flush_e_i(flush_e_i),
    .ctrl_d_i(ctrl_d_i), .rs1_d_i(rs1_d_i), .rs2_d_i(rs2_d_i), .rd_d_i(rd_d_i),
    .rd1_d_i(rd1_d_i), .rd2_d_i(rd2_d_i), .imm_ext_d_i(imm_ext_d_i),
    .pc_f_o(pc_f_o), .instr_d_o(instr_d_o), .pc_d_o(pc_d_o), .pc_plus4_d_o(pc_plus4_d_o),
    .valid_d_o(valid_d_o), .ctrl_e_o(ctrl_e_o), .rs1_e_o(rs1_e_o), .rs2_e_o(rs2_e_o),
    .rd_e_o(rd_e_o), .rd1_e_o(rd1_e_o), .rd2_e_o(rd2_e_o), .imm_ext_e_o(imm_ext_e_o),
    .pc_e_o(pc_e_o), .pc_plus4_e_o(pc_plus4_e_o), .valid_e_o(valid_e_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: one record per pipeline stage.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } dec_t;

  typedef struct {
    logic [9:0]  ctrl;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic        valid;
  } exe_t;

  logic [31:0] m_pc;
  dec_t        m_dec;
  exe_t        m_exe;
  longint      m_bubbles;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exe_t empty_exe();
    exe_t e;
    e.ctrl = '0; e.rs1 = '0; e.rs2 = '0; e.rd = '0;
    e.rd1 = '0; e.rd2 = '0; e.imm = '0; e.pc = '0; e.pc4 = '0; e.valid = 1'b0;
    return e;
  endfunction

  task automatic model_reset();
    m_pc        = 32'h0;
    m_dec.instr = 32'h0000_0013;
    m_dec.pc    = '0;
    m_dec.valid = 1'b0;
    m_exe       = empty_exe();
    m_bubbles   = 0;
  endtask

  task automatic model_advance();
    exe_t next_exe;
    if (rst_i) begin
      model_reset();
      return;
    end
    next_exe = empty_exe();
    if (!flush_e_i) begin
      next_exe.ctrl  = m_dec.valid ? 10'(ctrl_d_i) : 10'd0;
      next_exe.rs1   = rs1_d_i;  next_exe.rs2 = rs2_d_i;  next_exe.rd = rd_d_i;
      next_exe.rd1   = rd1_d_i;  next_exe.rd2 = rd2_d_i;  next_exe.imm = imm_ext_d_i;
      next_exe.pc    = m_dec.valid ? m_dec.pc : 32'd0;
      next_exe.pc4   = m_dec.valid ? 32'((64'(m_dec.pc) + 64'd4) % 64'h1_0000_0000) : 32'd0;
      next_exe.valid = m_dec.valid;
    end
    if (flush_e_i || !m_dec.valid) m_bubbles = (m_bubbles < 64'hFFFF_FFFF) ? m_bubbles + 1 : m_bubbles;
    if (flush_d_i) begin
      m_dec.instr = 32'h0000_0013; m_dec.pc = '0; m_dec.valid = 1'b0;
    end else if (!stall_d_i) begin
      m_dec.instr = instr_f_i; m_dec.pc = m_pc; m_dec.valid = 1'b1;
    end
    m_exe = next_exe;
    if (!stall_f_i) m_pc = pc_next_f_i;
  endtask

  task automatic compare_all(input string name);
    logic [31:0] exp_pc4_d;
    exp_pc4_d = m_dec.valid ? 32'((64'(m_dec.pc) + 64'd4) % 64'h1_0000_0000) : 32'd0;
    check({name, ".pc_f"},     64'(pc_f_o),       64'(m_pc));
    check({name, ".instr_d"},  64'(instr_d_o),    64'(m_dec.instr));
    check({name, ".pc_d"},     64'(pc_d_o),       64'(m_dec.pc));
    check({name, ".pc4_d"},    64'(pc_plus4_d_o), 64'(exp_pc4_d));
    check({name, ".valid_d"},  64'(valid_d_o),    64'(m_dec.valid));
    check({name, ".ctrl_e"},   64'(ctrl_e_o),     64'(m_exe.ctrl));
    check({name, ".regs_e"},   64'({rs1_e_o, rs2_e_o, rd_e_o}), 64'({m_exe.rs1, m_exe.rs2, m_exe.rd}));
    check({name, ".rd12_e"},   {rd1_e_o, rd2_e_o}, {m_exe.rd1, m_exe.rd2});
    check({name, ".imm_e"},    64'(imm_ext_e_o),  64'(m_exe.imm));
    check({name, ".pcs_e"},    {pc_e_o, pc_plus4_e_o}, {m_exe.pc, m_exe.pc4});
    check({name, ".valid_e"},  64'(valid_e_o),    64'(m_exe.valid));
    check({name, ".bubbles"},  64'(bubble_cnt_o), 64'(m_bubbles));
  endtask

  task automatic randomize_data();
    logic [9:0] c;
    c           = 10'($urandom);
    ctrl_d_i    = c;
    instr_f_i   = $urandom;
    rs1_d_i     = 5'($urandom); rs2_d_i = 5'($urandom); rd_d_i = 5'($urandom);
    rd1_d_i     = $urandom; rd2_d_i = $urandom; imm_ext_d_i = $urandom;
  endtask

  // Apply the current inputs across one rising edge, then compare.
  task automatic step(input string name, input logic rst, input logic sf, input logic sd,
                      input logic fd, input logic fe, input logic [31:0] pc_next);
    rst_i = rst; stall_f_i = sf; stall_d_i = sd; flush_d_i = fd; flush_e_i = fe;
    pc_next_f_i = pc_next;
    randomize_data();
    @(posedge clk_i);
    model_advance();
    #1;
    compare_all(name);
    $display("step %-8s rst=%0b sf=%0b sd=%0b fd=%0b fe=%0b pc_f=%h instr_d=%h v_d=%0b v_e=%0b bub=%0d",
             name, rst, sf, sd, fd, fe, pc_f_o, instr_d_o, valid_d_o, valid_e_o, bubble_cnt_o);
  endtask

  initial begin
    logic [31:0] held_instr;
    rst_i = 1'b1; stall_f_i = 0; stall_d_i = 0; flush_d_i = 0; flush_e_i = 0;
    pc_next_f_i = 32'h0;
    randomize_data();
    model_reset();
    #2;

    step("reset", 1, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) step("seq", 0, 0, 0, 0, 0, m_pc + 32'd4);

    held_instr = instr_d_o;
    step("loaduse", 0, 1, 1, 0, 1, m_pc + 32'd4);
    check("loaduse.held", 64'(instr_d_o), 64'(held_instr));
    step("resume", 0, 0, 0, 0, 0, m_pc + 32'd4);

    step("branch", 0, 0, 0, 1, 1, 32'h100);
    check("branch.nop", 64'(instr_d_o), 64'h13);
    step("seq", 0, 0, 0, 0, 0, m_pc + 32'd4);

    step("stlflush", 0, 0, 1, 1, 0, m_pc + 32'd4);
    step("wrap_pc", 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
    step("wrap_cap", 0, 0, 0, 0, 0, 32'h0);
    check("wrap.pc4_zero", 64'(pc_plus4_d_o), 64'h0);

    step("to40", 0, 0, 0, 0, 0, 32'h40);
    step("rststall", 1, 1, 1, 0, 0, 32'h44);
    step("postrst", 0, 0, 0, 0, 0, 32'h4);

    for (int i = 0; i < 600; i++) begin
      logic r, sf, sd, fd, fe;
      logic [31:0] nxt;
      r   = ($urandom_range(0, 63) == 0);
      sd  = ($urandom_range(0, 3) == 0);
      sf  = sd ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      fd  = ($urandom_range(0, 7) == 0);
      fe  = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 9))
        0:       nxt = 32'hFFFF_FFFC;
        1, 2:    nxt = $urandom & 32'hFFFF_FFFC;
        default: nxt = m_pc + 32'd4;
      endcase
      step("rand", r, sf, sd, fd, fe, nxt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
